// File: rtl/adder_io_sequencer.sv
// ---------------------------------------------------------------------------
// adder_io_sequencer
//
// GPIO-side sequencer for the 4-bit-pin adder user project. A host clocks
// nibbles in on nib_i, one per rising edge of nib_stb_i. The first N nibbles
// build operand A and the next N build operand B, least-significant nibble
// first. The operands go to the adder core over a valid/ready handshake. The
// WIDTH+1-bit sum is captured when sum_valid_i is seen. It is then returned
// on nib_o, one nibble per host strobe, least-significant nibble first. The
// carry is sent as the final, zero-extended nibble.
//
// Configuration macro:
//   ADDER_SEQ_SYNC_EN  when defined, nib_stb_i and nib_i pass through 2-flop
//                      synchronizers before edge detection. A strobe then
//                      takes 3 cycles to reach the operand registers.
//                      When undefined, the pads are sampled directly and the
//                      strobe takes 1 cycle. Use the undefined build only
//                      with a host that runs synchronously to wb_clk_i.
//
// Parameters:
//   WIDTH        operand width in bits, multiple of 4, at least 4
//
// Ports:
//   wb_clk_i     in   1        clock
//   wb_rst_n     in   1        asynchronous active-low reset
//   nib_i        in   4        nibble from the GPIO pads
//   nib_stb_i    in   1        host strobe; each rising edge is one transfer
//   op_a_o       out  WIDTH    operand A to the adder
//   op_b_o       out  WIDTH    operand B to the adder
//   op_valid_o   out  1        operands valid
//   op_ready_i   in   1        adder accepts operands
//   sum_i        in   WIDTH+1  sum from the adder, bit WIDTH is the carry
//   sum_valid_i  in   1        sum valid, single-cycle or held
//   nib_o        out  4        nibble to the GPIO pads
//   nib_oeb_o    out  4        pad output enable, active-low (4'hF = hi-Z)
//   busy_o       out  1        high whenever the FSM is not in LOAD_A
//   ovr_o        out  1        sticky; a strobe arrived while not accepting
// ---------------------------------------------------------------------------
module adder_io_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n,
   input  logic [3:0]       nib_i,
   input  logic             nib_stb_i,
   output logic [WIDTH-1:0] op_a_o,
   output logic [WIDTH-1:0] op_b_o,
   output logic             op_valid_o,
   input  logic             op_ready_i,
   input  logic [WIDTH:0]   sum_i,
   input  logic             sum_valid_i,
   output logic [3:0]       nib_o,
   output logic [3:0]       nib_oeb_o,
   output logic             busy_o,
   output logic             ovr_o
);

   // N nibbles per operand. M nibbles per result: the extra one holds the carry.
   localparam int N     = WIDTH / 4;
   localparam int M     = N + 1;
   localparam int RES_W = 4 * M;
   localparam int CNT_W = $clog2(N + 1);

   typedef enum logic [2:0] {
      LOAD_A,
      LOAD_B,
      ISSUE,
      WAIT_SUM,
      SEND
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   nib_cnt;
   logic [WIDTH:0]     result_q;

   // Input sampling stage. The strobe and the nibble are always taken from
   // the same stage, so the nibble that goes with a strobe edge stays aligned
   // with that edge.
   logic               stb_s;
   logic               stb_d;
   logic [3:0]         nib_s;
   logic               strobe_edge;

`ifdef ADDER_SEQ_SYNC_EN
   // Two-flop synchronizers for the asynchronous host pads. The sampling
   // stage below adds one more register, so a strobe takes 3 cycles to land.
   logic               stb_sync1;
   logic               stb_sync2;
   logic [3:0]         nib_sync1;
   logic [3:0]         nib_sync2;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         stb_sync1 <= 1'b0;
         stb_sync2 <= 1'b0;
         nib_sync1 <= 4'h0;
         nib_sync2 <= 4'h0;
      end else begin
         stb_sync1 <= nib_stb_i;
         stb_sync2 <= stb_sync1;
         nib_sync1 <= nib_i;
         nib_sync2 <= nib_sync1;
      end
   end

   // Sampling stage and previous-strobe register for edge detection.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         stb_s <= 1'b0;
         stb_d <= 1'b0;
         nib_s <= 4'h0;
      end else begin
         stb_s <= stb_sync2;
         stb_d <= stb_s;
         nib_s <= nib_sync2;
      end
   end
`else
   // The host runs synchronously to wb_clk_i, so the pads feed the sampling
   // stage directly. A strobe then takes one cycle to land.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         stb_s <= 1'b0;
         stb_d <= 1'b0;
         nib_s <= 4'h0;
      end else begin
         stb_s <= nib_stb_i;
         stb_d <= stb_s;
         nib_s <= nib_i;
      end
   end
`endif

   // One transfer per rising edge of the sampled strobe.
   assign strobe_edge = stb_s & ~stb_d;

   // Operands shift right by one nibble. The new nibble enters at the top,
   // so the first nibble received ends up least significant. The shift goes
   // through a widened temporary so that WIDTH == 4 needs no special case.
   logic [WIDTH+3:0]   shift_a_wide;
   logic [WIDTH+3:0]   shift_b_wide;
   logic [WIDTH-1:0]   shift_a;
   logic [WIDTH-1:0]   shift_b;

   assign shift_a_wide = {nib_s, op_a_o} >> 4;
   assign shift_b_wide = {nib_s, op_b_o} >> 4;
   assign shift_a      = shift_a_wide[WIDTH-1:0];
   assign shift_b      = shift_b_wide[WIDTH-1:0];

   // Zero-extend the captured sum to a whole number of nibbles. The carry
   // then occupies bit 0 of the top nibble.
   logic [RES_W-1:0]   res_ext;
   logic [CNT_W-1:0]   cnt_inc;
   logic [3:0]         next_send_nib;
   logic               last_op_nib;
   logic               last_res_nib;

   assign res_ext      = {{(RES_W - WIDTH - 1){1'b0}}, result_q};
   assign cnt_inc      = nib_cnt + CNT_W'(1);
   assign last_op_nib  = (nib_cnt == CNT_W'(N - 1));
   assign last_res_nib = (nib_cnt == CNT_W'(M - 1));

   // Select the result nibble that a SEND advance will present next.
   always_comb begin
      next_send_nib = 4'h0;
      for (int i = 0; i < M; i++) begin
         if (cnt_inc == CNT_W'(i)) begin
            next_send_nib = res_ext[4*i +: 4];
         end
      end
   end

   // Main sequencer. Every output is a register that is updated on the same
   // edge as the state change it reflects. op_valid_o, busy_o and the pad
   // drivers therefore always agree with the current state.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state      <= LOAD_A;
         nib_cnt    <= '0;
         result_q   <= '0;
         op_a_o     <= '0;
         op_b_o     <= '0;
         op_valid_o <= 1'b0;
         nib_o      <= 4'h0;
         nib_oeb_o  <= 4'hF;
         busy_o     <= 1'b0;
         ovr_o      <= 1'b0;
      end else begin
         case (state)
            LOAD_A: begin
               if (strobe_edge) begin
                  op_a_o <= shift_a;
                  if (last_op_nib) begin
                     nib_cnt <= '0;
                     state   <= LOAD_B;
                     busy_o  <= 1'b1;
                  end else begin
                     nib_cnt <= cnt_inc;
                  end
               end
            end

            LOAD_B: begin
               if (strobe_edge) begin
                  op_b_o <= shift_b;
                  if (last_op_nib) begin
                     nib_cnt    <= '0;
                     state      <= ISSUE;
                     op_valid_o <= 1'b1;
                  end else begin
                     nib_cnt <= cnt_inc;
                  end
               end
            end

            ISSUE: begin
               // The operands stay frozen until the adder takes them.
               // A strobe arriving here has nowhere to go.
               if (strobe_edge) begin
                  ovr_o <= 1'b1;
               end
               if (op_ready_i) begin
                  op_valid_o <= 1'b0;
                  state      <= WAIT_SUM;
               end
            end

            WAIT_SUM: begin
               if (strobe_edge) begin
                  ovr_o <= 1'b1;
               end
               if (sum_valid_i) begin
                  result_q  <= sum_i;
                  nib_cnt   <= '0;
                  nib_o     <= sum_i[3:0];
                  nib_oeb_o <= 4'h0;
                  state     <= SEND;
               end
            end

            SEND: begin
               // The host acknowledges each nibble with a strobe. The strobe
               // on the final nibble releases the pads and rearms for A.
               if (strobe_edge) begin
                  if (last_res_nib) begin
                     nib_cnt   <= '0;
                     nib_o     <= 4'h0;
                     nib_oeb_o <= 4'hF;
                     busy_o    <= 1'b0;
                     state     <= LOAD_A;
                  end else begin
                     nib_cnt <= cnt_inc;
                     nib_o   <= next_send_nib;
                  end
               end
            end

            default: begin
               state      <= LOAD_A;
               nib_cnt    <= '0;
               op_valid_o <= 1'b0;
               nib_o      <= 4'h0;
               nib_oeb_o  <= 4'hF;
               busy_o     <= 1'b0;
            end
         endcase
      end
   end

endmodule
